// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB3 bus bundle for apb_slave_regfile (PSTRB present under APB_PSTRB_EN)
interface apb_slave_regfile_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
`ifdef APB_PSTRB_EN
    logic [DATA_W/8-1:0] PSTRB;
`endif
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
`ifdef APB_PSTRB_EN
        output PSTRB,
`endif
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
`ifdef APB_PSTRB_EN
        input  PSTRB,
`endif
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB3 register file with wait states, PSLVERR and abort; byte strobes under APB_PSTRB_EN
module apb_slave_regfile #(
    parameter int              ADDR_W      = 12,
    parameter int              DATA_W      = 32,
    parameter int              NUM_REGS    = 8,
    parameter int              WAIT_STATES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    apb_slave_regfile_if.slave           apb,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);
    localparam int NB       = DATA_W / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = ADDR_W - ADDR_LSB;
    localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((32'd1 << ADDR_LSB) - 32'd1);
    localparam logic [3:0]        WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] prdata_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [IDX_W-1:0]  idx;
    logic [NB-1:0]     strb;
    logic              decode_err;
    logic              xfer_err;
    logic              acc_cyc;
    logic              setup_cyc;
    logic              wr_fire;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rdata_sel;

    assign idx        = apb.PADDR[ADDR_W-1:ADDR_LSB];
    assign decode_err = (32'(idx) >= 32'(NUM_REGS)) || (|(apb.PADDR & LSB_MASK));
    assign acc_cyc    = apb.PSEL & apb.PENABLE;
    assign setup_cyc  = apb.PSEL & ~apb.PENABLE;

`ifdef APB_PSTRB_EN
    assign strb     = apb.PSTRB;
    assign xfer_err = decode_err || (!apb.PWRITE && (|apb.PSTRB));
`else
    assign strb     = '1;
    assign xfer_err = decode_err;
`endif

    // The write lands on the edge that closes the cycle in which PREADY is high.
    assign wr_fire = pready_q & acc_cyc & apb.PWRITE & ~xfer_err;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(idx) == 32'(i)) rd_word = regs_q[i];
        end
    end

    assign rdata_sel = (xfer_err || apb.PWRITE) ? '0 : rd_word;

    // PREADY/PSLVERR/PRDATA are armed one edge ahead so they are high on ACCESS cycle WAIT_STATES+1.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            if (pready_q) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (setup_cyc) begin
                            state_q <= SETUP;
                            cnt_q   <= WAIT_CNT;
                            if (WAIT_STATES == 0) begin
                                pready_q  <= 1'b1;
                                pslverr_q <= xfer_err;
                                prdata_q  <= rdata_sel;
                            end
                        end
                    end
                    SETUP, ACCESS: begin
                        if (acc_cyc) begin
                            state_q <= ACCESS;
                            cnt_q   <= (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                            if (cnt_q <= 4'd1) begin
                                pready_q  <= 1'b1;
                                pslverr_q <= xfer_err;
                                prdata_q  <= rdata_sel;
                            end
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else if (wr_fire) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if ((32'(idx) == 32'(i)) && strb[b]) regs_q[i][b*8 +: 8] <= apb.PWDATA[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed + random bench for apb_slave_regfile (WAIT_STATES=2 and 0 instances)
module tb_apb_slave_regfile;
    localparam int NR = 8;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    apb_slave_regfile_if #(.ADDR_W(12), .DATA_W(32)) bus0 ();
    apb_slave_regfile_if #(.ADDR_W(12), .DATA_W(32)) bus1 ();
    logic [NR*32-1:0] regs0;
    logic [NR*32-1:0] regs1;

    apb_slave_regfile #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(NR), .WAIT_STATES(2), .RESET_VAL(32'h0))
        dut0 (.PCLK(PCLK), .PRESET(PRESET), .apb(bus0.slave), .reg_q(regs0));
    apb_slave_regfile #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(NR), .WAIT_STATES(0), .RESET_VAL(32'h0))
        dut1 (.PCLK(PCLK), .PRESET(PRESET), .apb(bus1.slave), .reg_q(regs1));

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ws_of [2] = '{2, 0};
    logic [31:0] model [2][NR];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic sel, input logic en, input logic wr,
                         input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        if (w == 0) begin
            bus0.PSEL = sel; bus0.PENABLE = en; bus0.PWRITE = wr; bus0.PADDR = a; bus0.PWDATA = d;
`ifdef APB_PSTRB_EN
            bus0.PSTRB = s;
`endif
        end else begin
            bus1.PSEL = sel; bus1.PENABLE = en; bus1.PWRITE = wr; bus1.PADDR = a; bus1.PWDATA = d;
`ifdef APB_PSTRB_EN
            bus1.PSTRB = s;
`endif
        end
    endtask

    task automatic sample(input int w, output logic rdy, output logic [31:0] rd, output logic er);
        if (w == 0) begin rdy = bus0.PREADY; rd = bus0.PRDATA; er = bus0.PSLVERR; end
        else        begin rdy = bus1.PREADY; rd = bus1.PRDATA; er = bus1.PSLVERR; end
    endtask

    task automatic regs_word(input int w, input int i, output logic [31:0] v);
        logic [NR*32-1:0] all;
        all = (w == 0) ? regs0 : regs1;
        v = all[i*32 +: 32];
    endtask

    task automatic check_regs(input int w, input string tag);
        logic [31:0] v;
        for (int i = 0; i < NR; i++) begin
            regs_word(w, i, v);
            check($sformatf("%s reg%0d", tag, i), v, model[w][i]);
        end
    endtask

    task automatic check_quiet(input int w, input string tag);
        logic rdy; logic [31:0] rd; logic er;
        sample(w, rdy, rd, er);
        check({tag, " PREADY"}, rdy, 0);
        check({tag, " PSLVERR"}, er, 0);
        check({tag, " PRDATA"}, rd, 0);
    endtask

    // One APB transfer; called and returns at #1 after a rising edge.
    task automatic xfer(input int w, input bit wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit keep, output logic [31:0] rd,
                        output logic er, output int cyc, output bit ok);
        logic rdy;
        drive(w, 1'b1, 1'b0, wr, a, d, s);
        @(posedge PCLK); #1;
        drive(w, 1'b1, 1'b1, wr, a, d, s);
        cyc = 1; ok = 0; rd = '0; er = 1'b0;
        repeat (40) begin
            sample(w, rdy, rd, er);
            if (rdy) begin ok = 1; break; end
            check("wait PRDATA", rd, 0);
            check("wait PSLVERR", er, 0);
            @(posedge PCLK); #1;
            cyc++;
        end
        @(posedge PCLK); #1;
        if (!keep) drive(w, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    endtask

    task automatic txn(input int w, input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit keep, input string tag);
        logic [31:0] rd; logic er; int cyc; bit ok; bit e; int idx;
        logic [3:0] st; logic [31:0] exp_rd;
        idx = int'(a >> 2);
        e = (idx >= NR) || (a[1:0] != 2'b00);
`ifdef APB_PSTRB_EN
        st = s;
        if (!wr && s != 4'h0) e = 1;
`else
        st = 4'hF;
`endif
        xfer(w, wr, a, d, s, keep, rd, er, cyc, ok);
        check({tag, " ready"}, ok, 1);
        check({tag, " latency"}, cyc, ws_of[w] + 1);
        check({tag, " pslverr"}, er, e);
        if (!wr) begin
            exp_rd = e ? 32'h0 : model[w][idx];
            check({tag, " prdata"}, rd, exp_rd);
        end
        if (wr && !e) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) model[w][idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [11:0] ra;
        logic [3:0]  rs;
        bit          rwr;
        int          w;

        drive(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) for (int i = 0; i < NR; i++) model[k][i] = 32'h0;

        repeat (3) @(posedge PCLK);
        #1;
        check_quiet(0, "rst0");
        check_quiet(1, "rst1");
        check("rst regs0", regs0, 0);
        PRESET = 1'b0;

        txn(0, 1, 12'h008, 32'h12345678, 4'hF, 0, "wr008");
        txn(0, 0, 12'h008, 32'h0, 4'h0, 0, "rd008");
        regs_word(0, 2, v);
        check("reg2 value", v, 32'h12345678);

        txn(0, 1, 12'h020, 32'hDEADBEEF, 4'hF, 0, "err_idx8");
        txn(0, 1, 12'h006, 32'hDEADBEEF, 4'hF, 0, "err_misal");
        check_regs(0, "after_err");

        txn(0, 1, 12'h004, 32'h0BADF00D, 4'hF, 0, "pre_abort");
        drive(0, 1'b1, 1'b0, 1'b1, 12'h004, 32'hA5A5A5A5, 4'hF);
        @(posedge PCLK); #1;
        drive(0, 1'b1, 1'b1, 1'b1, 12'h004, 32'hA5A5A5A5, 4'hF);
        check_quiet(0, "abort A1");
        @(posedge PCLK); #1;
        drive(0, 1'b0, 1'b0, 1'b1, 12'h004, 32'hA5A5A5A5, 4'hF);
        check_quiet(0, "abort A2");
        repeat (3) begin
            @(posedge PCLK); #1;
            check_quiet(0, "abort after");
        end
        regs_word(0, 1, v);
        check("abort reg1", v, 32'h0BADF00D);

        txn(1, 1, 12'h000, 32'h11111111, 4'hF, 1, "b2b0");
        txn(1, 1, 12'h004, 32'h22222222, 4'hF, 0, "b2b1");
        regs_word(1, 0, v);
        check("b2b reg0", v, 32'h11111111);
        regs_word(1, 1, v);
        check("b2b reg1", v, 32'h22222222);

`ifdef APB_PSTRB_EN
        txn(0, 1, 12'h000, 32'h11223344, 4'hF, 0, "strb_init");
        txn(0, 1, 12'h000, 32'hAABBCCDD, 4'b0101, 0, "strb_0101");
        regs_word(0, 0, v);
        check("strb reg0", v, 32'h11BB33DD);
        txn(0, 1, 12'h000, 32'hFFFFFFFF, 4'b0000, 0, "strb_none");
        txn(0, 0, 12'h000, 32'h0, 4'b0001, 0, "strb_rd_err");
        check_regs(0, "after_strb");
`endif

        for (int k = 0; k < 40; k++) begin
            w   = k % 2;
            ra  = ($urandom % 8 == 0) ? 12'($urandom_range(0, 47)) : 12'($urandom_range(0, 9) * 4);
            rwr = 1'($urandom % 2);
`ifdef APB_PSTRB_EN
            rs  = rwr ? 4'($urandom) : (($urandom % 4 == 0) ? 4'($urandom) : 4'h0);
`else
            rs  = 4'hF;
`endif
            txn(w, rwr, ra, $urandom, rs, 0, $sformatf("rnd%0d", k));
        end
        check_regs(0, "rnd end0");
        check_regs(1, "rnd end1");

        drive(0, 1'b1, 1'b0, 1'b1, 12'h00C, 32'hCAFEF00D, 4'hF);
        @(posedge PCLK); #1;
        drive(0, 1'b1, 1'b1, 1'b1, 12'h00C, 32'hCAFEF00D, 4'hF);
        PRESET = 1'b1;
        #1;
        check_quiet(0, "midrst async");
        repeat (3) @(posedge PCLK);
        #1;
        check_quiet(0, "midrst");
        check_quiet(1, "midrst1");
        check("midrst regs0", regs0, 0);
        check("midrst regs1", regs1, 0);
        PRESET = 1'b0;
        for (int k = 0; k < 2; k++) for (int i = 0; i < NR; i++) model[k][i] = 32'h0;
        repeat (4) begin
            @(posedge PCLK); #1;
            check_quiet(0, "idle penable");
        end
        regs_word(0, 3, v);
        check("idle penable reg3", v, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        @(posedge PCLK); #1;
        txn(0, 0, 12'h00C, 32'h0, 4'h0, 0, "post_rst_rd");
        txn(0, 1, 12'h01C, 32'h5A5A0F0F, 4'hF, 0, "post_rst_wr");
        check_regs(0, "final0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
Parametrised APB slave holding NUM_REGS read/write registers behind a configurable-latency APB3 interface. Successor to the fixed single-slave block driven through apb_top. Adds configurable wait states, PSLVERR on decode errors, abort on PSEL drop, and optional byte strobes. Register contents are exported on a flat bus for downstream logic.

Parameters:
ADDR_W, 12, PADDR width in bits
DATA_W, 32, PWDATA/PRDATA width; must be 8, 16 or 32
NUM_REGS, 8, number of registers; 1..2**(ADDR_W-ADDR_LSB)
WAIT_STATES, 2, cycles PREADY is held low in ACCESS before completion; 0..15
RESET_VAL, 0, reset value of every register (DATA_W bits)

Ports:
PCLK  in  1  clock, rising edge
PRESET  in  1  asynchronous, active-high reset
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  byte address
PWDATA  in  DATA_W  write data
PSTRB  in  DATA_W/8  byte strobes (present only with APB_PSTRB_EN)
PRDATA  out  DATA_W  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error, valid only with PREADY
reg_q  out  NUM_REGS*DATA_W  register contents; reg i at bits [i*DATA_W +: DATA_W]

Behaviour:
- ADDR_LSB = log2(DATA_W/8); index = PADDR[ADDR_W-1:ADDR_LSB].
- Decode error: index >= NUM_REGS, or PADDR[ADDR_LSB-1:0] != 0 (DATA_W > 8).
- FSM states IDLE, SETUP, ACCESS; all state registered, async-cleared by PRESET.
- IDLE: PSEL=1 & PENABLE=0 -> SETUP. PENABLE=1 while in IDLE is ignored (no transfer).
- SETUP: load wait counter with WAIT_STATES. Next cycle -> ACCESS if PSEL=1 & PENABLE=1; else -> IDLE.
- ACCESS: PREADY=0 while counter != 0; counter decrements each cycle. When counter = 0, PREADY=1 for exactly one cycle, i.e. on ACCESS cycle WAIT_STATES+1.
- Completion cycle (PREADY=1): write with no error -> register updated at that clock edge. Read -> PRDATA = register value. Error -> PSLVERR=1, no register change, PRDATA=0.
- After completion: PSEL=1 & PENABLE=0 -> SETUP (back-to-back); otherwise -> IDLE.
- PSEL=0 or PENABLE=0 during ACCESS before completion: abort. No write, PREADY/PSLVERR stay 0, counter cleared, -> IDLE.
- PADDR/PWRITE/PWDATA are sampled in the completion cycle; the master holds them stable per APB.
- Outputs are registered. PRDATA, PREADY and PSLVERR are 0 in every non-completion cycle.
- Reset (any time, including mid-transfer): state=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, all registers=RESET_VAL. Any in-flight write is lost.
- reg_q reflects register state continuously; it updates the cycle after the write edge.

Optional Feature:
APB_PSTRB_EN:
- Defined: PSTRB port exists. On a write, only byte lanes with PSTRB[b]=1 update; PSTRB=0 writes nothing but still completes with PSLVERR=0. A read with PSTRB != 0 completes with PSLVERR=1 and PRDATA=0.
- Undefined: no PSTRB port; writes update all bytes.

Test Plan:
- Reset: PRESET=1 for 3 cycles mid-SETUP -> PREADY=0, PSLVERR=0, PRDATA=0, reg_q all 0; FSM in IDLE after release.
- Write then read: write 0x12345678 to PADDR 0x008, then read 0x008 -> PREADY high on 3rd ACCESS cycle (WAIT_STATES=2); PRDATA=0x12345678; PSLVERR=0; reg_q[95:64]=0x12345678.
- Decode error: write 0xDEADBEEF to 0x020 (index 8), then to misaligned 0x006 -> PSLVERR=1 with PREADY for both; reg_q unchanged.
- Abort: drop PSEL on 2nd ACCESS cycle of a write of 0xA5A5A5A5 to 0x004 -> no PREADY; reg 1 keeps its old value.
- Back-to-back with WAIT_STATES=0: writes to 0x000 then 0x004 with no IDLE between -> PREADY on each first ACCESS cycle; both registers updated.
- APB_PSTRB_EN: reg 0=0x11223344; write 0xAABBCCDD with PSTRB=4'b0101 -> reg 0=0x11BB33DD. Read with PSTRB=4'b0001 -> PSLVERR=1.
